// File: rtl/complex_gate_arbiter.sv
// Round-robin arbiter sharing one AO/AOI complex-gate evaluator between NB_REQ
// requesters; the result and the winner's index are returned over valid/ready.
module complex_gate_arbiter #(
    parameter int NB_REQ = 4,
    parameter int WAY    = 3,
    parameter int ID_W   = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NB_REQ-1:0]       req,
    input  logic [NB_REQ-1:0]       op_sel,
    input  logic [NB_REQ*WAY-1:0]   operand,
    output logic [NB_REQ-1:0]       grant,
    output logic                    result_valid,
    output logic                    result,
    output logic [ID_W-1:0]         result_id,
    input  logic                    result_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t             state_reg;
    logic [ID_W-1:0]    ptr_reg;
    logic [ID_W-1:0]    idx_reg;
    logic [WAY-1:0]     operand_reg;
    logic               op_reg;

    logic [WAY-1:0]     operand_arr [NB_REQ];
    logic [ID_W-1:0]    win_idx;
    logic [ID_W:0]      cand;
    logic [NB_REQ-1:0]  win_onehot;
    logic [ID_W-1:0]    ptr_next;
    logic               ao;
    logic               gate_out;

    genvar gi;

    generate
        for (gi = 0; gi < NB_REQ; gi++) begin : g_unpack
            assign operand_arr[gi] = operand[gi*WAY +: WAY];
        end
    endgenerate

    // Scan from the highest rotated offset down so the candidate closest to
    // ptr (offset 0) is the last one written and therefore wins.
    always_comb begin
        win_idx = ptr_reg;
        cand    = '0;
        for (int k = NB_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, ptr_reg} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NB_REQ)) begin
                cand = cand - (ID_W+1)'(NB_REQ);
            end
            if (req[cand[ID_W-1:0]]) begin
                win_idx = cand[ID_W-1:0];
            end
        end
    end

    generate
        for (gi = 0; gi < NB_REQ; gi++) begin : g_onehot
            assign win_onehot[gi] = (win_idx == ID_W'(gi));
        end
    endgenerate

    assign ptr_next = (idx_reg == ID_W'(NB_REQ - 1)) ? '0 : idx_reg + ID_W'(1);

    // The evaluator: top input ORed with the AND of all lower inputs.
    assign ao       = (&operand_reg[WAY-2:0]) | operand_reg[WAY-1];
    assign gate_out = op_reg ? ~ao : ao;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            ptr_reg      <= '0;
            idx_reg      <= '0;
            operand_reg  <= '0;
            op_reg       <= 1'b0;
            grant        <= '0;
            result_valid <= 1'b0;
            result       <= 1'b0;
            result_id    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|req) begin
                        operand_reg <= operand_arr[win_idx];
                        op_reg      <= op_sel[win_idx];
                        idx_reg     <= win_idx;
                        grant       <= win_onehot;
                        state_reg   <= EVAL;
                    end else begin
                        grant <= '0;
                    end
                end
                EVAL: begin
                    grant        <= '0;
                    result       <= gate_out;
                    result_id    <= idx_reg;
                    result_valid <= 1'b1;
                    state_reg    <= HOLD;
                end
                HOLD: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        ptr_reg      <= ptr_next;
                        state_reg    <= IDLE;
                    end
                end
                default: begin
                    grant        <= '0;
                    result_valid <= 1'b0;
                    state_reg    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_complex_gate_arbiter.sv
// Self-checking bench for complex_gate_arbiter: truth-table vectors, a result
// scoreboard, and hand-written sequences for rotation, backpressure and reset.
module tb_complex_gate_arbiter;

    localparam int NB_REQ = 4;
    localparam int WAY    = 3;
    localparam int ID_W   = 2;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NB_REQ-1:0]     req;
    logic [NB_REQ-1:0]     op_sel;
    logic [NB_REQ*WAY-1:0] operand;
    logic [NB_REQ-1:0]     grant;
    logic                  result_valid;
    logic                  result;
    logic [ID_W-1:0]       result_id;
    logic                  result_ready;

    complex_gate_arbiter #(
        .NB_REQ(NB_REQ),
        .WAY   (WAY),
        .ID_W  (ID_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .op_sel      (op_sel),
        .operand     (operand),
        .grant       (grant),
        .result_valid(result_valid),
        .result      (result),
        .result_id   (result_id),
        .result_ready(result_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       res;
        logic [1:0] id;
    } exp_t;

    typedef struct {
        logic       op;
        logic [2:0] x;
        logic       expected;
    } vec_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    vec_t       tbl [16];
    logic [2:0] opd [NB_REQ];
    logic [3:0] ops;
    int         pass_cnt = 0;
    int         chk_cnt  = 0;
    int         txn_cnt  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_val);
        chk_cnt++;
        if (act === req_val) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req_val);
    endtask

    function automatic logic gate_model(input logic op, input logic [2:0] x);
        logic ao;
        ao = (x[0] & x[1]) | x[2];
        return op ? ~ao : ao;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ops();
        operand = {opd[3], opd[2], opd[1], opd[0]};
        op_sel  = ops;
    endtask

    task automatic wait_grant(input string name, output logic [3:0] g, output int n);
        n = 0;
        g = '0;
        for (int i = 0; i < 12; i++) begin
            tick();
            n++;
            if (grant != '0) break;
        end
        g = grant;
        if (g == '0) check({name, "_grant_timeout"}, 32'(g), 32'(1));
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 12; i++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        check({name, "_drain"}, 32'(exp_q.size()), 32'(0));
    endtask

    task automatic txn(input logic [3:0] req_v, input int id, input logic exp_res,
                       input string name);
        logic [3:0] g;
        int         n;
        exp_q.push_back('{exp_res, 2'(id)});
        req = req_v;
        wait_grant(name, g, n);
        check({name, "_grant"}, 32'(g), 32'(1) << id);
        req = '0;
        drain(name);
    endtask

    // Scoreboard: a handshake seen here is accepted on the following rising edge.
    always @(negedge clk) begin
        if (!reset && result_valid && result_ready) begin
            txn_cnt++;
            if (exp_q.size() == 0) begin
                check("sb_unexpected_result", 32'(1), 32'(0));
            end else begin
                mon_e = exp_q.pop_front();
                $display("txn %0d: id=%0d result=%0b (model id=%0d result=%0b)",
                         txn_cnt, result_id, result, mon_e.id, mon_e.res);
                check("sb_result", 32'(result), 32'(mon_e.res));
                check("sb_result_id", 32'(result_id), 32'(mon_e.id));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] g;
        int         n;
        logic       held_res;

        for (int i = 0; i < 16; i++) begin
            tbl[i].op       = (i >= 8);
            tbl[i].x        = 3'(i % 8);
            tbl[i].expected = ((i % 8) >= 3) ^ (i >= 8);
        end
        opd[0] = 3'b011;
        opd[1] = 3'b100;
        opd[2] = 3'b011;
        opd[3] = 3'b010;
        ops    = 4'b1010;

        reset        = 1'b1;
        req          = 4'b1111;
        result_ready = 1'b1;
        drive_ops();

        // Reset held two cycles with every requester asking.
        for (int c = 0; c < 2; c++) begin
            tick();
            check("rst_grant", 32'(grant), 32'(0));
            check("rst_valid", 32'(result_valid), 32'(0));
            check("rst_result", 32'(result), 32'(0));
            check("rst_result_id", 32'(result_id), 32'(0));
        end
        reset = 1'b0;
        txn(4'b1111, 0, gate_model(ops[0], opd[0]), "first_after_rst");

        // Single request, AO, exact cycle timing.
        exp_q.push_back('{1'b1, 2'd2});
        req = 4'b0100;
        tick();
        check("single_grant", 32'(grant), 32'(4'b0100));
        req = '0;
        tick();
        check("single_grant_clear", 32'(grant), 32'(0));
        check("single_valid", 32'(result_valid), 32'(1));
        check("single_result", 32'(result), 32'(1));
        check("single_result_id", 32'(result_id), 32'(2));
        tick();
        check("single_valid_drop", 32'(result_valid), 32'(0));
        drain("single");

        // Truth table on requester 0.
        for (int i = 0; i < 16; i++) begin
            opd[0] = tbl[i].x;
            ops[0] = tbl[i].op;
            drive_ops();
            txn(4'b0001, 0, tbl[i].expected, "truth");
        end
        opd[0] = 3'b011;
        ops[0] = 1'b0;
        drive_ops();

        // Round-robin rotation with all requesters held high.
        txn(4'b1000, 3, gate_model(ops[3], opd[3]), "rr_pre");
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back('{gate_model(ops[i % 4], opd[i % 4]), 2'(i % 4)});
        end
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_grant("rr", g, n);
            check("rr_grant", 32'(g), 32'(1) << (i % 4));
            if (i > 0) check("rr_spacing", 32'(n), 32'(3));
        end
        req = '0;
        drain("rr");

        // Wrap to ptr=0, then backpressure for five cycles.
        txn(4'b1000, 3, gate_model(ops[3], opd[3]), "wrap_pre");
        result_ready = 1'b0;
        held_res = gate_model(ops[0], opd[0]);
        exp_q.push_back('{held_res, 2'd0});
        req = 4'b1001;
        wait_grant("bp", g, n);
        check("bp_grant", 32'(g), 32'(4'b0001));
        req = 4'b1000;
        tick();
        for (int c = 0; c < 5; c++) begin
            check("bp_valid_hold", 32'(result_valid), 32'(1));
            check("bp_result_hold", 32'(result), 32'(held_res));
            check("bp_result_id_hold", 32'(result_id), 32'(0));
            tick();
        end
        result_ready = 1'b1;
        exp_q.push_back('{gate_model(ops[3], opd[3]), 2'd3});
        wait_grant("bp_next", g, n);
        check("bp_next_grant", 32'(g), 32'(4'b1000));
        req = '0;
        drain("bp");

        // Reset while a result waits in HOLD.
        result_ready = 1'b0;
        req = 4'b0100;
        wait_grant("mid", g, n);
        check("mid_grant", 32'(g), 32'(4'b0100));
        req = '0;
        tick();
        check("mid_valid", 32'(result_valid), 32'(1));
        tick();
        reset = 1'b1;
        tick();
        check("mid_rst_valid", 32'(result_valid), 32'(0));
        check("mid_rst_result", 32'(result), 32'(0));
        check("mid_rst_result_id", 32'(result_id), 32'(0));
        check("mid_rst_grant", 32'(grant), 32'(0));
        exp_q.delete();
        reset        = 1'b0;
        result_ready = 1'b1;
        txn(4'b0110, 1, gate_model(ops[1], opd[1]), "post_rst");

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
